// File: rtl/mov_seq_scheduler_if.sv
// Bundle between mov_seq_scheduler, the external combinational block
// generator (restrectedMovSeq) and the downstream move consumer.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics.
//   - A move transfers on a rising clk edge where out_valid && out_ready.
//   - Once out_valid is high it stays high, and out_move stays stable,
//     until the transfer happens.
//   - out_valid never depends combinationally on out_ready.
// Generator path: gen_restrected/gen_prob/gen_random are registered
// outputs of the scheduler; gen_seq returns combinationally from them.
interface mov_seq_scheduler_if;
  logic [1:0]  gen_restrected;
  logic [2:0]  gen_prob;
  logic [12:0] gen_random;
  logic [7:0]  gen_seq;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_move;

  // Scheduler side
  modport master (
    output gen_restrected,
    output gen_prob,
    output gen_random,
    input  gen_seq,
    output out_valid,
    input  out_ready,
    output out_move
  );

  // Generator + consumer side
  modport slave (
    input  gen_restrected,
    input  gen_prob,
    input  gen_random,
    output gen_seq,
    input  out_valid,
    output out_ready,
    input  out_move
  );
endinterface

// File: rtl/mov_seq_scheduler.sv
// mov_seq_scheduler: drives the restricted-move block generator from a
// 13-bit Fibonacci LFSR and serialises each 4-move block (low bits first)
// to a valid/ready consumer, one move per transfer.
// Block cadence: one LOAD cycle (captures gen_seq, advances LFSR) followed
// by four EMIT transfers. The last move of each block becomes the
// restricted move of the next block.
// Optional feature macro: MOVSEQ_HEAD_STATS_EN adds head_cnt, counting
// blocks whose first move is the restricted move.
module mov_seq_scheduler #(
  parameter logic [12:0] SEED = 13'h1ACE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [2:0]            cfg_prob,
  input  logic [1:0]            cfg_init_restr,
  mov_seq_scheduler_if.master   bus,
  output logic                  busy,
  output logic [1:0]            dbg_state,
  output logic [15:0]           block_cnt
`ifdef MOVSEQ_HEAD_STATS_EN
  ,
  output logic [15:0]           head_cnt
`endif
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [12:0] SEED_EFF = (SEED == 13'h0000) ? 13'h0001 : SEED;

  logic [1:0]  r_state;
  logic [12:0] r_lfsr;
  logic [1:0]  r_restr;
  logic [2:0]  r_prob;
  logic [7:0]  r_shift;
  logic [1:0]  r_idx;
  logic [15:0] r_block_cnt;

  logic [12:0] w_lfsr_next;
  logic        w_start_ok;
  logic        w_xfer;
  logic        w_last;

  // Fibonacci feedback: shift left, taps 12,3,2,0 into the LSB.
  assign w_lfsr_next = {r_lfsr[11:0], r_lfsr[12] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0]};

  // start is only honoured from IDLE; it beats a simultaneous stop there.
  assign w_start_ok = (r_state == ST_IDLE) && start;

  // A move leaves on every EMIT cycle the consumer is ready.
  assign w_xfer = (r_state == ST_EMIT) && bus.out_ready;

  // The fourth transfer closes the block.
  assign w_last = w_xfer && (r_idx == 2'd3);

  // Control FSM: IDLE -> LOAD -> EMIT x4 -> LOAD/IDLE (stop sampled at block end)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (w_last) begin
            r_state <= stop ? ST_IDLE : ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Generator configuration: latched on start; restricted move chains from
  // the last emitted move of each block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prob  <= 3'd0;
      r_restr <= 2'd0;
    end else if (w_start_ok) begin
      r_prob  <= cfg_prob;
      r_restr <= cfg_init_restr;
    end else if (w_last) begin
      r_restr <= r_shift[1:0];
    end
  end

  // LFSR advances exactly once per LOAD cycle, never otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED_EFF;
    end else if (r_state == ST_LOAD) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Block shift register and move index; frozen under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= 8'd0;
      r_idx   <= 2'd0;
    end else if (r_state == ST_LOAD) begin
      r_shift <= bus.gen_seq;
      r_idx   <= 2'd0;
    end else if (w_xfer) begin
      r_shift <= {2'b00, r_shift[7:2]};
      r_idx   <= r_idx + 2'd1;
    end
  end

  // Completed-block counter, cleared on start, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_block_cnt <= 16'd0;
    end else if (w_start_ok) begin
      r_block_cnt <= 16'd0;
    end else if (w_last) begin
      r_block_cnt <= r_block_cnt + 16'd1;
    end
  end

`ifdef MOVSEQ_HEAD_STATS_EN
  logic [15:0] r_head_cnt;

  // Count LOAD cycles where the generator put the restricted move first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_cnt <= 16'd0;
    end else if (w_start_ok) begin
      r_head_cnt <= 16'd0;
    end else if ((r_state == ST_LOAD) && (bus.gen_seq[1:0] == r_restr)) begin
      r_head_cnt <= r_head_cnt + 16'd1;
    end
  end

  assign head_cnt = r_head_cnt;
`endif

  // Output mapping: everything is a direct register view.
  assign bus.gen_restrected = r_restr;
  assign bus.gen_prob       = r_prob;
  assign bus.gen_random     = r_lfsr;
  assign bus.out_valid      = (r_state == ST_EMIT);
  assign bus.out_move       = r_shift[1:0];
  assign busy               = (r_state != ST_IDLE);
  assign dbg_state          = r_state;
  assign block_cnt          = r_block_cnt;

endmodule

// File: tb/tb_mov_seq_scheduler.sv
// Bench for mov_seq_scheduler: a behavioural generator stands in for
// restrectedMovSeq, a reference model predicts the move stream into
// exp_q, and a negedge monitor pops and compares on every transfer.
module tb_mov_seq_scheduler;
  localparam logic [12:0] SEED = 13'h1ACE;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  cfg_prob = 3'd0;
  logic [1:0]  cfg_init_restr = 2'd0;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [15:0] block_cnt;
`ifdef MOVSEQ_HEAD_STATS_EN
  logic [15:0] head_cnt;
`endif

  always #5 clk = ~clk;

  mov_seq_scheduler_if bus();

  mov_seq_scheduler #(.SEED(SEED)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .cfg_prob       (cfg_prob),
    .cfg_init_restr (cfg_init_restr),
    .bus            (bus.master),
    .busy           (busy),
    .dbg_state      (dbg_state),
    .block_cnt      (block_cnt)
`ifdef MOVSEQ_HEAD_STATS_EN
    ,
    .head_cnt       (head_cnt)
`endif
  );

  // ---------------- reference functions ----------------
  function automatic logic [12:0] lfsr_next(input logic [12:0] q);
    return {q[11:0], q[12] ^ q[3] ^ q[2] ^ q[0]};
  endfunction

  // Behavioural generator: a permutation of the four moves. The restricted
  // move goes first with probability prob/64 (rnd[5:0] < prob), else last;
  // rnd[12:6] picks one of the six orders of the remaining three.
  function automatic logic [7:0] gen_model(input logic [12:0] rnd,
                                           input logic [1:0] r,
                                           input logic [2:0] p);
    logic [1:0] oth [3];
    logic [1:0] a, b, c;
    int k, sel, i, s;
    k = 0;
    for (int m = 0; m < 4; m++) begin
      if (m[1:0] != r) begin
        oth[k] = m[1:0];
        k++;
      end
    end
    sel = int'(rnd[12:6]) % 6;
    i = sel / 2;
    s = sel % 2;
    a = oth[i];
    b = oth[(i + 1 + s) % 3];
    c = oth[(i + 2 - s) % 3];
    if (int'(rnd[5:0]) < int'(p)) return {c, b, a, r};
    else                          return {r, c, b, a};
  endfunction

  always_comb bus.gen_seq = gen_model(bus.gen_random, bus.gen_restrected, bus.gen_prob);

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  int         xfer_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] blk [4];
  int         mon_pos = 0;
  logic [1:0] mon_prev = 2'd0;
  int         mon_heads = 0;
  bit         mon_case1 = 1'b0;

  logic [12:0] m_lfsr;
  logic [1:0]  m_restr;
  logic [2:0]  m_prob;
  int          m_heads;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one whole block at a time.
  task automatic push_block();
    logic [7:0] s;
    s = gen_model(m_lfsr, m_restr, m_prob);
    if (s[1:0] == m_restr) m_heads++;
    for (int i = 0; i < 4; i++) exp_q.push_back(s[2*i +: 2]);
    m_restr = s[7:6];
    m_lfsr  = lfsr_next(m_lfsr);
  endtask

  // Monitor: counts a transfer at the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_move: got 0x%0h expected none", bus.out_move);
      end else begin
        chk("move", 32'(bus.out_move), 32'(exp_q.pop_front()));
      end
      blk[mon_pos] = bus.out_move;
      mon_pos++;
      xfer_cnt++;
      if (mon_pos == 4) begin
        logic distinct;
        distinct = (blk[0] != blk[1]) && (blk[0] != blk[2]) && (blk[0] != blk[3]) &&
                   (blk[1] != blk[2]) && (blk[1] != blk[3]) && (blk[2] != blk[3]);
        chk("block_distinct", 32'(distinct), 32'd1);
        if (mon_case1) chk("case1_last_move", 32'(blk[3]), 32'd2);
        if (blk[0] == mon_prev) mon_heads++;
        mon_prev = blk[3];
        mon_pos = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset(input string tag);
    chk({tag, "_busy"},      32'(busy),               32'd0);
    chk({tag, "_valid"},     32'(bus.out_valid),      32'd0);
    chk({tag, "_move"},      32'(bus.out_move),       32'd0);
    chk({tag, "_block_cnt"}, 32'(block_cnt),          32'd0);
    chk({tag, "_random"},    32'(bus.gen_random),     32'(SEED));
    chk({tag, "_restr"},     32'(bus.gen_restrected), 32'd0);
    chk({tag, "_prob"},      32'(bus.gen_prob),       32'd0);
  endtask

  // Run n blocks. mode 0: ready tied high; mode 1: random ready plus
  // ignored start/stop noise. stall_at/abort_at: transfer index within
  // the run at which to stall 10 cycles / assert async reset (-1 = never).
  task automatic run_blocks(input int n, input logic [2:0] prob, input logic [1:0] restr,
                            input int mode, input int stall_at, input int abort_at,
                            input bit c1);
    logic [12:0] lfsr0;
    int base, cyc, rel, budget;
    bit stalled;
    m_prob  = prob;
    m_restr = restr;
    m_heads = 0;
    lfsr0   = m_lfsr;
    for (int b = 0; b < n; b++) push_block();
    mon_pos   = 0;
    mon_prev  = restr;
    mon_heads = 0;
    mon_case1 = c1;
    base      = xfer_cnt;
    budget    = n * 20 + 50;

    @(posedge clk); #1;
    cfg_prob       = prob;
    cfg_init_restr = restr;
    start          = 1'b1;
    stop           = (mode == 1);
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    stop           = 1'b0;
    cfg_prob       = 3'($urandom);
    cfg_init_restr = 2'($urandom);
    @(negedge clk);
    chk("load_busy",   32'(busy),           32'd1);
    chk("load_valid",  32'(bus.out_valid),  32'd0);
    chk("load_random", 32'(bus.gen_random), 32'(lfsr0));
    @(negedge clk);
    chk("first_valid",   32'(bus.out_valid),  32'd1);
    chk("emit_random",   32'(bus.gen_random), 32'(lfsr_next(lfsr0)));
    chk("blk_cnt_clear", 32'(block_cnt),      32'd0);

    cyc = 0;
    stalled = 1'b0;
    rel = xfer_cnt - base;
    while (rel < 4 * n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      rel = xfer_cnt - base;
      if (rel == abort_at) begin
        #2 rst = 1'b1;
        #1 check_reset("abort");
        exp_q.delete();
        m_lfsr = SEED;
        start = 1'b0;
        stop = 1'b0;
        bus.out_ready = 1'b0;
        #3 rst = 1'b0;
        return;
      end
      if (rel == stall_at && !stalled) begin
        stalled = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("stall_valid",  32'(bus.out_valid),  32'd1);
          chk("stall_move",   32'(bus.out_move),   32'(exp_q[0]));
          chk("stall_random", 32'(bus.gen_random), 32'(m_lfsr));
          @(posedge clk); #1;
          cyc++;
        end
        rel = xfer_cnt - base;
      end
      if (mode == 0) bus.out_ready = 1'b1;
      else           bus.out_ready = ($urandom_range(0, 3) != 0);
      if (rel >= 4 * n - 2)                      stop = 1'b1;
      else if (mode == 1 && (rel % 4) != 3)      stop = ($urandom_range(0, 3) == 0);
      else                                       stop = 1'b0;
      if (mode == 1 && rel < 4 * n - 1) start = ($urandom_range(0, 9) == 0);
      else                               start = 1'b0;
    end
    chk("run_done", 32'(rel), 32'(4 * n));
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy",      32'(busy),           32'd0);
    chk("idle_block_cnt", 32'(block_cnt),      32'(n));
    chk("idle_random",    32'(bus.gen_random), 32'(m_lfsr));
    chk("exp_q_drained",  32'(exp_q.size()),   32'd0);
    chk("head_model",     32'(mon_heads),      32'(m_heads));
`ifdef MOVSEQ_HEAD_STATS_EN
    chk("head_cnt",       32'(head_cnt),       32'(m_heads));
`endif
    stop = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [12:0] p_start;
    longint diff;
    bus.out_ready = 1'b0;
    m_lfsr = SEED;
    #1 rst = 1'b1;
    #2 check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // prob 0, restricted 2: 100 blocks, every 4th move is 2
    run_blocks(100, 3'd0, 2'd2, 0, -1, -1, 1'b1);
    // backpressure at idx 1, stop during idx 2
    run_blocks(1, 3'd3, 2'd1, 0, 1, -1, 1'b0);
    // random ready with ignored start/stop noise
    run_blocks(20, 3'd5, 2'd3, 1, -1, -1, 1'b0);
    run_blocks(15, 3'd2, 2'd0, 1, -1, -1, 1'b0);
    // async reset at idx 2, then restart from SEED
    run_blocks(2, 3'd4, 2'd1, 0, -1, 2, 1'b0);
    run_blocks(3, 3'd4, 2'd1, 0, -1, -1, 1'b0);
    // prob 7 over one full LFSR period
    p_start = m_lfsr;
    run_blocks(8191, 3'd7, 2'd0, 0, -1, -1, 1'b0);
    chk("lfsr_period", 32'(bus.gen_random), 32'(p_start));
    diff = 64'(6400) * longint'(mon_heads) - 64'(700) * 64'(8191);
    if (diff < 0) diff = -diff;
    chk("head_fraction", 32'(diff <= 64'(128) * 64'(8191)), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
